qadd_share_arb: RTL and testbench

- Shares one fixed-point adder instance (`qadd`, Q/N format, two's-complement, wrap-around sum) between NREQ requesters in the systolic-array accumulation path.
- Arbitrates round-robin, registers one result, and returns it with the requester ID over a valid/ready response channel.
- Flags signed overflow of each sum.
- Sits between the PE-column partial-sum outputs and the accumulator/output buffer.

---
 rtl/qadd_arb_pkg.sv | 24 ++
 rtl/qadd.sv | 28 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/qadd_share_arb.sv | 127 ++++++++++++
 tb/tb_qadd_share_arb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qadd_arb_pkg.sv
// ============================================================================
// Module      : qadd_arb_pkg
// Description : Default sizing constants and ID-width helper for the shared
//               fixed-point adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qadd_arb_pkg;

    localparam int c_NREQ_DEF = 4;
    localparam int c_N_DEF    = 32;
    localparam int c_Q_DEF    = 15;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qadd.sv
// ============================================================================
// Module      : qadd
// Description : Two's-complement Q/N fixed-point adder, wrap-around sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qadd #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    // Fractional and integer fields are added separately; the fractional
    // carry feeds the integer field, so the result equals a+b mod 2^N.
    logic [Q:0]     w_frac;
    logic [N-Q-1:0] w_int;

    assign w_frac = {1'b0, i_a[Q-1:0]} + {1'b0, i_b[Q-1:0]};
    assign w_int  = i_a[N-1:Q] + i_b[N-1:Q] + (N-Q)'(w_frac[Q]);
    assign o_sum  = {w_int, w_frac[Q-1:0]};

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; grants the first request
//               at or after i_ptr, searching cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_gnt_idx
);

    logic           w_hit_hi;
    logic           w_hit_lo;
    logic [IDW-1:0] w_idx_hi;
    logic [IDW-1:0] w_idx_lo;

    // When nothing is found at or above the pointer, the lowest asserted
    // request overall is the cyclic successor.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_req[i] && !w_hit_hi && (i >= int'(i_ptr))) begin
                w_hit_hi = 1'b1;
                w_idx_hi = IDW'(i);
            end
            if (i_req[i] && !w_hit_lo) begin
                w_hit_lo = 1'b1;
                w_idx_lo = IDW'(i);
            end
        end
    end

    assign o_gnt_idx = w_hit_hi ? w_idx_hi : w_idx_lo;

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = i_en & (w_hit_hi | w_hit_lo) & (o_gnt_idx == IDW'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/qadd_share_arb.sv
// ============================================================================
// Module      : qadd_share_arb
// Description : Round-robin sharing of one qadd between NREQ requesters with
//               a single registered valid/ready result and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qadd_share_arb
    import qadd_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEF,
    parameter int N    = c_N_DEF,
    parameter int Q    = c_Q_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [N-1:0]              rsp_data,
    output logic [id_width(NREQ)-1:0] rsp_id,
    output logic                      rsp_ovf,
    output logic                      busy
);

    localparam int IDW = id_width(NREQ);

    logic [0:0]     r_state_q,    w_state_d;
    logic [N-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic [IDW-1:0] r_rsp_id_q,   w_rsp_id_d;
    logic           r_rsp_ovf_q,  w_rsp_ovf_d;
    logic [IDW-1:0] r_rr_ptr_q,   w_rr_ptr_d;

    logic            w_can_accept;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_xfer;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [N-1:0]    w_sum;
    logic            w_ovf;

    // A full register that is being drained this cycle can take a new result.
    assign w_can_accept = (r_state_q == c_ST_EMPTY) | rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr_q),
        .i_en      (w_can_accept & ~rst),
        .o_grant   (w_grant),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_xfer = |w_grant;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_a = req_a[i*N +: N];
                w_b = req_b[i*N +: N];
            end
        end
    end

    qadd #(
        .Q (Q),
        .N (N)
    ) u_qadd (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    assign w_ovf = (w_a[N-1] == w_b[N-1]) & (w_sum[N-1] != w_a[N-1]);

    always_comb begin
        w_state_d    = r_state_q;
        w_rsp_data_d = r_rsp_data_q;
        w_rsp_id_d   = r_rsp_id_q;
        w_rsp_ovf_d  = r_rsp_ovf_q;
        w_rr_ptr_d   = r_rr_ptr_q;
        if (w_xfer) begin
            w_state_d    = c_ST_FULL;
            w_rsp_data_d = w_sum;
            w_rsp_id_d   = w_gnt_idx;
            w_rsp_ovf_d  = w_ovf;
            w_rr_ptr_d   = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end else if ((r_state_q == c_ST_FULL) && rsp_ready) begin
            w_state_d = c_ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_EMPTY;
            r_rsp_data_q <= '0;
            r_rsp_id_q   <= '0;
            r_rsp_ovf_q  <= 1'b0;
            r_rr_ptr_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_id_q   <= w_rsp_id_d;
            r_rsp_ovf_q  <= w_rsp_ovf_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = (r_state_q == c_ST_FULL);
    assign rsp_data  = r_rsp_data_q;
    assign rsp_id    = r_rsp_id_q;
    assign rsp_ovf   = r_rsp_ovf_q;
    assign busy      = rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_qadd_share_arb.sv
// ============================================================================
// Module      : tb_qadd_share_arb
// Description : Scoreboard testbench for qadd_share_arb (NREQ=4, N=32, Q=15).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qadd_share_arb;

    localparam int NREQ = 4;
    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ovf;
    logic              busy;

    qadd_share_arb #(
        .NREQ (NREQ),
        .N    (N),
        .Q    (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]   data;
        logic [IDW-1:0] id;
        logic           ovf;
    } rsp_t;

    rsp_t            sb[$];
    int              n_vec = 0;
    int              n_bad = 0;
    logic [N-1:0]    op_a[NREQ];
    logic [N-1:0]    op_b[NREQ];
    logic [NREQ-1:0] v;
    bit              refill;
    int              m_ptr;
    logic [N-1:0]    held;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic pack();
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = op_a[i];
            req_b[i*N +: N] = op_b[i];
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        int           g;
        bit           can;
        rsp_t         r;
        logic [N-1:0] s;
        @(negedge clk);
        can = (sb.size() == 0) || rsp_ready;
        g   = (rst || !can) ? -1 : model_grant();
        check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        check("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
        check("busy", 64'(busy), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
            check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
            check("rsp_ovf", 64'(rsp_ovf), 64'(sb[0].ovf));
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end else begin
            if (sb.size() != 0 && rsp_ready) void'(sb.pop_front());
            if (g >= 0) begin
                s      = op_a[g] + op_b[g];
                r.data = s;
                r.id   = IDW'(g);
                r.ovf  = (op_a[g][N-1] == op_b[g][N-1]) && (s[N-1] != op_a[g][N-1]);
                sb.push_back(r);
                m_ptr = (g + 1) % NREQ;
                if (refill) begin
                    op_a[g] = $urandom;
                    op_b[g] = $urandom;
                end else begin
                    v[g] = 1'b0;
                end
            end
        end
        #1;
        pack();
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        v[i]    = 1'b1;
        op_a[i] = a;
        op_b[i] = b;
        pack();
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        refill    = 1'b0;
        v         = '0;
        m_ptr     = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pack();
        step();
        step();
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_data", 64'(rsp_data), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
        check("reset_ovf", 64'(rsp_ovf), 64'd0);
        rst = 1'b0;

        // Single requester, 1.0 + 0.5
        rsp_ready = 1'b1;
        set_req(1, 32'h0000_8000, 32'h0000_4000);
        step();
        check("single_data", 64'(rsp_data), 64'h0000_C000);
        check("single_id", 64'(rsp_id), 64'd1);
        check("single_ovf", 64'(rsp_ovf), 64'd0);
        step();

        // All requesters continuously valid from a fresh pointer
        rst = 1'b1;
        step();
        rst    = 1'b0;
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_order", 64'(rsp_id), 64'(k % NREQ));
        end

        // Backpressure while full
        rsp_ready = 1'b0;
        step();
        held = rsp_data;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_stable", 64'(rsp_data), 64'(held));
        end
        rsp_ready = 1'b1;
        step();
        check("refill_valid", 64'(rsp_valid), 64'd1);
        refill = 1'b0;
        v      = '0;
        pack();
        step();
        step();

        // Overflow boundaries
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        check("ovf_pos_data", 64'(rsp_data), 64'h8000_0000);
        check("ovf_pos_flag", 64'(rsp_ovf), 64'd1);
        set_req(3, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        check("ovf_wrap_data", 64'(rsp_data), 64'd0);
        check("ovf_wrap_flag", 64'(rsp_ovf), 64'd0);
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        step();
        check("ovf_neg_flag", 64'(rsp_ovf), 64'd1);

        // Fairness after a grant to 2
        set_req(0, 32'd5, 32'd6);
        set_req(3, 32'd7, 32'd8);
        step();
        check("fair_first", 64'(rsp_id), 64'd3);
        step();
        check("fair_second", 64'(rsp_id), 64'd0);
        step();

        // Reset mid-operation with a full register and pending requests
        refill    = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        refill    = 1'b0;
        rsp_ready = 1'b1;
        v         = 4'b0101;
        pack();
        step();
        check("rst_mid_first", 64'(rsp_id), 64'd0);
        step();
        step();

        // Random traffic with random backpressure
        for (int k = 0; k < 60; k++) begin
            refill    = ($urandom_range(0, 3) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) set_req(i, $urandom, $urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
